uk_frame_mac: RTL
=================

Name: uk_frame_mac

Overview:
- Frame-level multiply-accumulate stage wrapped around the Uk coefficient ROM.
- Drives the ROM address `add` and consumes its registered output `Ukp` one cycle later.
- Multiplies each accepted speech sample by its Uk coefficient and accumulates over a frame of FRAME_LEN samples.
- Presents the frame sum, with a one-cycle done pulse, to the downstream scoring logic.

Parameters:
FRAME_LEN  256  samples per frame, legal 1..256; coefficient index runs 0..FRAME_LEN-1
ACC_W      24   accumulator/result width, legal 16..32

Ports:
CS          input   1      clock, rising edge; the same clock that drives the Uk ROM
cen         input   1      asynchronous active-low reset
start       input   1      begin a frame; sampled only in IDLE
sample_in   input   8      unsigned speech sample
sample_valid input  1      sample_in is valid this cycle
sample_ready output 1      block accepts a sample this cycle
add         output  8      ROM address (coefficient index)
Ukp         input   8      ROM data; equals ROM[add] registered at the previous CS edge
acc_out     output  ACC_W  frame result; held until the next start
done        output  1      one-cycle pulse when acc_out updates
busy        output  1      high in RUN and DRAIN

Behaviour:
- Reset (cen=0, async):
  - state=IDLE; idx, add, sample_q, pair_v, acc, acc_out, done all 0.
  - sample_ready=0, busy=0.
- States:
  - IDLE: start=1 → RUN; clears acc and idx, add=0.
  - RUN: sample_ready=1 while cnt<FRAME_LEN.
    - Accept = sample_valid & sample_ready.
    - On accept at edge t: sample_q<=sample_in, pair_v<=1, idx<=idx+1, add<=idx+1 (low 8 bits), cnt<=cnt+1.
    - Cycle with no accept: pair_v<=0, idx holds.
    - Accept of sample number FRAME_LEN → DRAIN.
  - DRAIN: sample_ready=0; one cycle to retire the final pair → DONE.
  - DONE: acc_out<=final acc, done=1 for exactly one cycle → IDLE.
- Pairing and latency:
  - The sample accepted at edge t uses address idx.
  - Ukp=ROM[idx] is valid in cycle t+1 while pair_v=1.
  - At edge t+1: acc<=acc+(sample_q*Ukp).
  - done rises two cycles after the last accept (DRAIN, then DONE).
- Arithmetic:
  - Unsigned 8x8 → 16-bit product, zero-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W (see Optional Feature).
- Counters:
  - cnt is 9 bits, so FRAME_LEN=256 terminates correctly.
  - add wraps 255→0 after the last accept; that value is unused.
- Other conditions:
  - start while busy or in DONE: ignored.
  - sample_valid outside RUN: ignored; sample_ready=0.
  - Gaps in sample_valid stall idx/add. No pair is lost, because Ukp is re-registered every CS edge from a stable add.
  - FRAME_LEN=1: one accept, then DRAIN, then DONE.
- Reset mid-frame: all state cleared immediately; a partial frame produces no done and acc_out=0.
- acc_out changes only in DONE or on reset.

Optional Feature:
- Macro UK_MAC_SAT_EN.
- Defined: accumulation saturates at 2^ACC_W-1. A sticky output `sat` (1 bit) is set on any clamp during the frame, cleared on start and reset, and is valid with done.
- Undefined: wrap-around accumulation and no `sat` port.

Test Plan:
- FRAME_LEN=4, ROM[0]=0, ROM[1..3]=2, samples 10,20,30,40 back-to-back → add sequence 0,1,2,3; acc_out=180; done pulses 2 cycles after the 4th accept.
- Same frame with sample_valid deasserted 3 cycles between each sample → acc_out=180; add holds during gaps.
- cen pulsed low after 2 accepts, then a new start with samples 5,5,5,5 → no done before reset; acc_out=0 during the reset; then acc_out=30.
- FRAME_LEN=256, all samples 255, ROM 0/2 → acc_out=255*2*255=130050; add wraps to 0; done once.
- start asserted during RUN and DONE → ignored; frame result unchanged; a later IDLE start clears acc.
- ACC_W=16, UK_MAC_SAT_EN, FRAME_LEN=256, samples 255 → acc_out=65535, sat=1. Without the macro → acc_out=130050 mod 65536=64514.

Source files
------------

// File: rtl/uk_frame_mac.sv
// Frame multiply-accumulate around the Uk coefficient ROM: pairs each accepted sample with ROM[idx] one cycle later.
// Optional saturation and sticky `sat` output enabled by defining UK_MAC_SAT_EN.
module uk_frame_mac #(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned ACC_W     = 24
) (
    input  logic             CS,
    input  logic             cen,
    input  logic             start,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic [7:0]       add,
    input  logic [7:0]       Ukp,
    output logic [ACC_W-1:0] acc_out,
    output logic             done,
    output logic             busy
`ifdef UK_MAC_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam int unsigned CNT_W  = 9;
    localparam int unsigned PROD_W = 16;
`ifdef UK_MAC_SAT_EN
    localparam int unsigned SUM_W  = ACC_W + 1;
`else
    localparam int unsigned SUM_W  = ACC_W;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         sample_q, sample_d;
    logic               pair_v_q, pair_v_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   acc_out_q, acc_out_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               sat_q, sat_d;

    logic               accept;
    logic [PROD_W-1:0]  prod;
    logic [SUM_W-1:0]   sum;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        pair_v_d  = 1'b0;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        done_d    = 1'b0;
        sat_d     = sat_q;

        accept = sample_valid & ready_q;
        prod   = PROD_W'(sample_q) * PROD_W'(Ukp);
        sum    = SUM_W'(acc_q) + SUM_W'(prod);

        // Ukp for the previously accepted sample is valid exactly while pair_v_q is set
        if (pair_v_q) begin
`ifdef UK_MAC_SAT_EN
            if (sum[ACC_W]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
`else
            acc_d = sum;
`endif
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    acc_d   = '0;
                    idx_d   = 8'd0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    sample_d = sample_in;
                    pair_v_d = 1'b1;
                    idx_d    = idx_q + 8'd1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                acc_out_d = acc_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == RUN);
        busy_d  = (state_d == RUN) || (state_d == DRAIN);
    end

    // State and datapath registers
    always_ff @(posedge CS or negedge cen) begin
        if (!cen) begin
            state_q   <= IDLE;
            idx_q     <= 8'd0;
            cnt_q     <= '0;
            sample_q  <= 8'd0;
            pair_v_q  <= 1'b0;
            acc_q     <= '0;
            acc_out_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            pair_v_q  <= pair_v_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            sat_q     <= sat_d;
        end
    end

    assign sample_ready = ready_q;
    assign add          = idx_q;
    assign acc_out      = acc_out_q;
    assign done         = done_q;
    assign busy         = busy_q;
`ifdef UK_MAC_SAT_EN
    assign sat          = sat_q;
`else
    logic unused_sat;
    assign unused_sat   = sat_q;
`endif

endmodule
